// File: rtl/amo_shim_pkg.sv
// Shared types and helpers for the atomic shim: AMO opcodes, lane decode and
// the LR/SC reservation entry.
package amo_shim_pkg;

  typedef enum logic [3:0] {
    AmoNone = 4'h0,
    AmoSwap = 4'h1,
    AmoAdd  = 4'h2,
    AmoAnd  = 4'h3,
    AmoOr   = 4'h4,
    AmoXor  = 4'h5,
    AmoMax  = 4'h6,
    AmoMaxu = 4'h7,
    AmoMin  = 4'h8,
    AmoMinu = 4'h9,
    AmoCas  = 4'hA,
    AmoLr   = 4'hB,
    AmoSc   = 4'hC
  } amo_op_t;

  // Fixed upper bounds so the helpers and the entry type are parameter-free.
  localparam int unsigned MaxBeWidth   = 128;
  localparam int unsigned MaxAddrWidth = 64;
  localparam int unsigned MaxLaneWidth = 5;

  typedef struct packed {
    logic                    valid;
    logic [MaxAddrWidth-1:0] addr;
    logic [MaxLaneWidth-1:0] lane;
  } resv_t;

  // Lowest 32-bit lane whose first byte enable is set; lane 0 when none is.
  function automatic logic [MaxLaneWidth-1:0] lane_of_be(input logic [MaxBeWidth-1:0] be,
                                                         input int unsigned num_lanes);
    logic [MaxLaneWidth-1:0] lane;
    lane = '0;
    for (int k = 31; k >= 0; k--) begin
      if ((k < int'(num_lanes)) && be[4*k]) lane = MaxLaneWidth'(k);
    end
    return lane;
  endfunction

endpackage

// File: rtl/amo_alu.sv
// Combinational 32-bit AMO datapath: old value a, operand b, CAS swap value.
module amo_alu
  import amo_shim_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] swap_i,
  output logic [31:0] result_o
);

  logic        a_lt_b_s;
  logic        a_lt_b_u;
  logic [31:0] unused_diff_s;
  logic [31:0] unused_diff_u;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and a latch is inferred.
  always_comb begin
    {a_lt_b_s, unused_diff_s} = {a_i[31], a_i} - {b_i[31], b_i};
    {a_lt_b_u, unused_diff_u} = {1'b0, a_i} - {1'b0, b_i};
    result_o = '0;
    case (amo_op_t'(op_i))
      AmoSwap: result_o = b_i;
      AmoAdd:  result_o = a_i + b_i;
      AmoAnd:  result_o = a_i & b_i;
      AmoOr:   result_o = a_i | b_i;
      AmoXor:  result_o = a_i ^ b_i;
      AmoMax:  result_o = a_lt_b_s ? b_i : a_i;
      AmoMaxu: result_o = a_lt_b_u ? b_i : a_i;
      AmoMin:  result_o = a_lt_b_s ? a_i : b_i;
      AmoMinu: result_o = a_lt_b_u ? a_i : b_i;
      AmoCas:  result_o = (a_i == b_i) ? swap_i : a_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/amo_shim_lrsc.sv
// Atomic shim owning one TCDM bank: 2-cycle AMOs on any 32-bit lane, plus
// per-ID LR/SC reservations when AMO_SHIM_LRSC_EN is defined.
module amo_shim_lrsc
  import amo_shim_pkg::*;
#(
  parameter int unsigned AddrMemWidth = 32,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned NumIds       = 8,
  parameter int unsigned IdWidth      = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_req_i,
  output logic                    in_gnt_o,
  input  logic [AddrMemWidth-1:0] in_add_i,
  input  logic [3:0]              in_amo_i,
  input  logic                    in_wen_i,
  input  logic [DataWidth-1:0]    in_wdata_i,
  input  logic [DataWidth/8-1:0]  in_be_i,
  input  logic [IdWidth-1:0]      in_id_i,
  output logic [DataWidth-1:0]    in_rdata_o,
  output logic                    out_req_o,
  output logic [AddrMemWidth-1:0] out_add_o,
  output logic                    out_wen_o,
  output logic [DataWidth-1:0]    out_wdata_o,
  output logic [DataWidth/8-1:0]  out_be_o,
  input  logic [DataWidth-1:0]    out_rdata_i
);

  localparam int unsigned NumLanes  = DataWidth / 32;
  localparam int unsigned LaneWidth = (NumLanes > 1) ? $clog2(NumLanes) : 1;

  if (((DataWidth % 32) != 0) || (DataWidth < 32) || (DataWidth > 1024) ||
      (AddrMemWidth > MaxAddrWidth) || (IdWidth < $clog2(NumIds))) begin : g_bad_cfg
    $fatal(1, "amo_shim_lrsc: unsupported parameter set");
  end

  typedef enum logic {StIdle, StDoAmo} state_t;

  state_t                  state_q, state_d;
  amo_op_t                 op_q, op_d;
  logic [AddrMemWidth-1:0] addr_q, addr_d;
  logic [LaneWidth-1:0]    lane_q, lane_d;
  logic [31:0]             b_q, b_d;
  logic [31:0]             swap_q, swap_d;
  logic                    sc_q, sc_d;
  logic                    sc_fail_q, sc_fail_d;

  amo_op_t              in_op;
  logic [LaneWidth-1:0] in_lane;
  logic [31:0]          in_b;
  logic [31:0]          in_swap;
  logic                 in_is_amo;
  logic                 idle_req;
  logic                 sc_hit;
  logic [31:0]          old_word;
  logic [31:0]          alu_result;
  logic [31:0]          wr_word;

  function automatic logic [DataWidth-1:0] place_word(input logic [31:0] w,
                                                      input logic [LaneWidth-1:0] l);
    logic [DataWidth-1:0] d;
    d = '0;
    d[32*l +: 32] = w;
    return d;
  endfunction

  function automatic logic [DataWidth/8-1:0] lane_be(input logic [LaneWidth-1:0] l);
    logic [DataWidth/8-1:0] be;
    be = '0;
    be[4*l +: 4] = 4'hF;
    return be;
  endfunction

  assign in_op     = amo_op_t'(in_amo_i);
  assign in_lane   = LaneWidth'(lane_of_be(MaxBeWidth'(in_be_i), NumLanes));
  assign in_is_amo = (in_amo_i >= 4'(AmoSwap)) && (in_amo_i <= 4'(AmoCas));
  assign idle_req  = (state_q == StIdle) && in_req_i && !rst_i;
  assign old_word  = out_rdata_i[32*lane_q +: 32];

  always_comb begin
    int lane_nxt;
    in_b     = in_wdata_i[32*in_lane +: 32];
    in_swap  = '0;
    lane_nxt = int'(in_lane) + 1;
    if (lane_nxt < int'(NumLanes)) in_swap = in_wdata_i[32*lane_nxt +: 32];
  end

  amo_alu u_alu (
    .op_i     (op_q),
    .a_i      (old_word),
    .b_i      (b_q),
    .swap_i   (swap_q),
    .result_o (alu_result)
  );

  // CAS needs an even lane with a partner lane above it; otherwise rewrite old.
  assign wr_word = ((op_q == AmoCas) && ((NumLanes < 2) || lane_q[0])) ? old_word : alu_result;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    lane_d      = lane_q;
    b_d         = b_q;
    swap_d      = swap_q;
    sc_d        = 1'b0;
    sc_fail_d   = 1'b0;
    in_gnt_o    = 1'b0;
    out_req_o   = in_req_i;
    out_add_o   = in_add_i;
    out_wen_o   = in_wen_i;
    out_wdata_o = in_wdata_i;
    out_be_o    = in_be_i;
    in_rdata_o  = sc_q ? place_word({31'b0, sc_fail_q}, lane_q) : out_rdata_i;

    case (state_q)
      StIdle: begin
        in_gnt_o = in_req_i;
        if (in_req_i) begin
          if (in_is_amo) begin
            out_wen_o = 1'b0;
            op_d      = in_op;
            addr_d    = in_add_i;
            lane_d    = in_lane;
            b_d       = in_b;
            swap_d    = in_swap;
            state_d   = StDoAmo;
          end else if (in_op == AmoLr) begin
            out_wen_o = 1'b0;
          end else if (in_op == AmoSc) begin
            lane_d    = in_lane;
            sc_d      = 1'b1;
            sc_fail_d = !sc_hit;
            if (sc_hit) begin
              out_wen_o = 1'b1;
              out_be_o  = lane_be(in_lane);
            end else begin
              out_req_o = 1'b0;
            end
          end
        end
      end
      StDoAmo: begin
        out_req_o   = 1'b1;
        out_wen_o   = 1'b1;
        out_add_o   = addr_q;
        out_be_o    = lane_be(lane_q);
        out_wdata_o = place_word(wr_word, lane_q);
        in_rdata_o  = place_word(old_word, lane_q);
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (rst_i) begin
      out_req_o = 1'b0;
      in_gnt_o  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      op_q      <= AmoNone;
      addr_q    <= '0;
      lane_q    <= '0;
      b_q       <= '0;
      swap_q    <= '0;
      sc_q      <= 1'b0;
      sc_fail_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      lane_q    <= lane_d;
      b_q       <= b_d;
      swap_q    <= swap_d;
      sc_q      <= sc_d;
      sc_fail_q <= sc_fail_d;
    end
  end

`ifdef AMO_SHIM_LRSC_EN
  resv_t resv_q [NumIds];
  resv_t resv_d [NumIds];
  logic  id_ok;
  logic  lr_go;
  logic  sc_go;

  assign id_ok = (32'(in_id_i) < NumIds);
  assign lr_go = idle_req && (in_op == AmoLr) && id_ok;
  assign sc_go = idle_req && (in_op == AmoSc) && id_ok;

  always_comb begin
    sc_hit = 1'b0;
    if (id_ok) begin
      sc_hit = resv_q[in_id_i].valid &&
               (resv_q[in_id_i].addr == MaxAddrWidth'(in_add_i)) &&
               (resv_q[in_id_i].lane == MaxLaneWidth'(in_lane));
    end
  end

  // Any write reaching the bank kills reservations on the lanes it touches.
  always_comb begin
    resv_d = resv_q;
    if (out_req_o && out_wen_o) begin
      for (int unsigned i = 0; i < NumIds; i++) begin
        for (int unsigned l = 0; l < NumLanes; l++) begin
          if (resv_q[i].valid && (resv_q[i].addr == MaxAddrWidth'(out_add_o)) &&
              (resv_q[i].lane == MaxLaneWidth'(l)) && (|out_be_o[4*l +: 4])) begin
            resv_d[i].valid = 1'b0;
          end
        end
      end
    end
    if (lr_go) begin
      resv_d[in_id_i] = '{valid: 1'b1, addr: MaxAddrWidth'(in_add_i),
                          lane: MaxLaneWidth'(in_lane)};
    end
    if (sc_go) resv_d[in_id_i].valid = 1'b0;
  end

  // NOTE: this is a small flop table, so the whole of it is reset; only the
  // valid bits matter, but clearing entries outright keeps them deterministic.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NumIds; i++) resv_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NumIds; i++) resv_q[i] <= resv_d[i];
    end
  end
`else
  logic unused_id;
  assign unused_id = ^in_id_i;
  assign sc_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_amo_shim_lrsc.sv
// Directed bench for amo_shim_lrsc (DataWidth=64) with a 1-cycle SRAM model.
module tb_amo_shim_lrsc;
  import amo_shim_pkg::*;

`ifdef AMO_SHIM_LRSC_EN
  localparam bit LrscEn = 1'b1;
`else
  localparam bit LrscEn = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_req;
  logic        in_gnt;
  logic [31:0] in_add;
  logic [3:0]  in_amo;
  logic        in_wen;
  logic [63:0] in_wdata;
  logic [7:0]  in_be;
  logic [2:0]  in_id;
  logic [63:0] in_rdata;
  logic        out_req;
  logic [31:0] out_add;
  logic        out_wen;
  logic [63:0] out_wdata;
  logic [7:0]  out_be;
  logic [63:0] out_rdata;

  logic [63:0] mem [16];
  int          n_tests = 0;
  int          n_fail  = 0;

  amo_shim_lrsc #(
    .AddrMemWidth (32),
    .DataWidth    (64),
    .NumIds       (8),
    .IdWidth      (3)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_req_i    (in_req),
    .in_gnt_o    (in_gnt),
    .in_add_i    (in_add),
    .in_amo_i    (in_amo),
    .in_wen_i    (in_wen),
    .in_wdata_i  (in_wdata),
    .in_be_i     (in_be),
    .in_id_i     (in_id),
    .in_rdata_o  (in_rdata),
    .out_req_o   (out_req),
    .out_add_o   (out_add),
    .out_wen_o   (out_wen),
    .out_wdata_o (out_wdata),
    .out_be_o    (out_be),
    .out_rdata_i (out_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM: read data appears the cycle after the request.
  always @(posedge clk) begin
    if (out_req) begin
      out_rdata <= mem[4'(out_add)];
      if (out_wen) begin
        for (int i = 0; i < 8; i++) begin
          if (out_be[i]) mem[4'(out_add)][8*i +: 8] <= out_wdata[8*i +: 8];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of master inputs at the falling edge, then let them settle.
  task automatic step(input logic req, input logic [3:0] amo, input logic wen,
                      input logic [31:0] add, input logic [63:0] wdata,
                      input logic [7:0] be, input logic [2:0] id);
    @(negedge clk);
    in_req   = req;
    in_amo   = amo;
    in_wen   = wen;
    in_add   = add;
    in_wdata = wdata;
    in_be    = be;
    in_id    = id;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 4'(AmoNone), 1'b0, 32'd0, 64'd0, 8'h00, 3'd0);
  endtask

  task automatic store(input logic [31:0] add, input logic [63:0] wdata, input logic [7:0] be,
                       input logic [2:0] id);
    step(1'b1, 4'(AmoNone), 1'b1, add, wdata, be, id);
  endtask

  initial begin
    rst       = 1'b1;
    out_rdata = '0;
    step(1'b1, 4'(AmoAdd), 1'b0, 32'd4, 64'd0, 8'hFF, 3'd0);
    check("rst_out_req", 64'(out_req), 64'd0);
    check("rst_gnt", 64'(in_gnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();

    // AMOAdd on the upper lane
    store(32'd4, 64'h0000_0005_0000_1111, 8'hFF, 3'd0);
    step(1'b1, 4'(AmoAdd), 1'b0, 32'd4, 64'h0000_0003_0000_0000, 8'hF0, 3'd0);
    check("add_c0_gnt", 64'(in_gnt), 64'd1);
    check("add_c0_read", 64'({out_req, out_wen}), 64'b10);
    idle();
    check("add_c1_gnt", 64'(in_gnt), 64'd0);
    check("add_c1_rdata", in_rdata, 64'h0000_0005_0000_0000);
    check("add_c1_wr", 64'({out_req, out_wen}), 64'b11);
    check("add_c1_be", 64'(out_be), 64'hF0);
    check("add_c1_wdata", out_wdata, 64'h0000_0008_0000_0000);
    check("add_c1_add", 64'(out_add), 64'd4);
    idle();
    check("add_mem", mem[4], 64'h0000_0008_0000_1111);

    // Signed vs unsigned minimum, then XOR
    store(32'd5, 64'h0000_0000_FFFF_FFFE, 8'hFF, 3'd0);
    step(1'b1, 4'(AmoMin), 1'b0, 32'd5, 64'h0000_0000_0000_0001, 8'h0F, 3'd0);
    idle();
    check("min_wdata", out_wdata, 64'h0000_0000_FFFF_FFFE);
    check("min_rdata", in_rdata, 64'h0000_0000_FFFF_FFFE);
    step(1'b1, 4'(AmoMinu), 1'b0, 32'd5, 64'h0000_0000_0000_0001, 8'h0F, 3'd0);
    idle();
    check("minu_wdata", out_wdata, 64'h0000_0000_0000_0001);
    check("minu_rdata", in_rdata, 64'h0000_0000_FFFF_FFFE);
    step(1'b1, 4'(AmoXor), 1'b0, 32'd5, 64'h0000_0000_0000_0003, 8'h0F, 3'd0);
    idle();
    check("xor_wdata", out_wdata, 64'h0000_0000_0000_0002);

    // CAS on lane 0: match, mismatch; then odd lane rewrites old
    store(32'd6, 64'h0000_0000_0000_0007, 8'hFF, 3'd0);
    step(1'b1, 4'(AmoCas), 1'b0, 32'd6, 64'h0000_0009_0000_0007, 8'h0F, 3'd0);
    idle();
    check("cas_eq_wdata", out_wdata, 64'h0000_0000_0000_0009);
    check("cas_eq_be", 64'(out_be), 64'h0F);
    check("cas_eq_rdata", in_rdata, 64'h0000_0000_0000_0007);
    store(32'd6, 64'h0000_0000_0000_0007, 8'hFF, 3'd0);
    step(1'b1, 4'(AmoCas), 1'b0, 32'd6, 64'h0000_0009_0000_0006, 8'h0F, 3'd0);
    idle();
    check("cas_ne_wdata", out_wdata, 64'h0000_0000_0000_0007);
    store(32'd6, 64'h0000_0007_0000_0007, 8'hFF, 3'd0);
    step(1'b1, 4'(AmoCas), 1'b0, 32'd6, 64'h0000_0007_0000_0009, 8'hF0, 3'd0);
    idle();
    check("cas_odd_wdata", out_wdata, 64'h0000_0007_0000_0000);
    check("cas_odd_be", 64'(out_be), 64'hF0);

    // LR / SC on id 2
    store(32'd8, 64'h0000_0022_0000_0011, 8'hFF, 3'd0);
    step(1'b1, 4'(AmoLr), 1'b0, 32'd8, 64'd0, 8'h0F, 3'd2);
    check("lr_gnt", 64'(in_gnt), 64'd1);
    check("lr_read", 64'({out_req, out_wen}), 64'b10);
    step(1'b1, 4'(AmoSc), 1'b1, 32'd8, 64'h0000_0000_0000_0055, 8'h0F, 3'd2);
    check("sc1_out_req", 64'(out_req), LrscEn ? 64'd1 : 64'd0);
    check("sc1_gnt", 64'(in_gnt), 64'd1);
    step(1'b1, 4'(AmoSc), 1'b1, 32'd8, 64'h0000_0000_0000_0066, 8'h0F, 3'd2);
    check("sc1_resp", in_rdata, LrscEn ? 64'd0 : 64'd1);
    check("sc2_out_req", 64'(out_req), 64'd0);
    check("sc2_gnt", 64'(in_gnt), 64'd1);
    idle();
    check("sc2_resp", in_rdata, 64'd1);
    check("sc_mem", 64'(mem[8][31:0]), LrscEn ? 64'h55 : 64'h11);

    // Overlapping store from id 3 breaks id 1's reservation
    step(1'b1, 4'(AmoLr), 1'b0, 32'd8, 64'd0, 8'h0F, 3'd1);
    store(32'd8, 64'h0000_0000_0000_00AA, 8'h03, 3'd3);
    step(1'b1, 4'(AmoSc), 1'b1, 32'd8, 64'h0000_0000_0000_0077, 8'h0F, 3'd1);
    check("sc_inv_out_req", 64'(out_req), 64'd0);
    idle();
    check("sc_inv_resp", in_rdata, 64'd1);

    // Store to the other lane leaves it intact
    step(1'b1, 4'(AmoLr), 1'b0, 32'd8, 64'd0, 8'h0F, 3'd1);
    store(32'd8, 64'h0000_00BB_0000_0000, 8'hF0, 3'd3);
    step(1'b1, 4'(AmoSc), 1'b1, 32'd8, 64'h0000_0000_0000_0077, 8'h0F, 3'd1);
    check("sc_keep_out_req", 64'(out_req), LrscEn ? 64'd1 : 64'd0);
    idle();
    check("sc_keep_resp", in_rdata, LrscEn ? 64'd0 : 64'd1);

    // SC failure on lane 1 reports in lane 1
    step(1'b1, 4'(AmoSc), 1'b1, 32'd8, 64'h0000_0001_0000_0000, 8'hF0, 3'd5);
    check("sc_hi_out_req", 64'(out_req), 64'd0);
    idle();
    check("sc_hi_resp", in_rdata, 64'h0000_0001_0000_0000);

    // Back-to-back AMOs, then reset during the second writeback
    store(32'd9, 64'h0000_0000_0000_000A, 8'hFF, 3'd0);
    step(1'b1, 4'(AmoAdd), 1'b0, 32'd9, 64'h0000_0000_0000_0005, 8'h0F, 3'd0);
    check("b2b_c0_gnt", 64'(in_gnt), 64'd1);
    step(1'b1, 4'(AmoSwap), 1'b0, 32'd9, 64'h0000_0000_0000_0077, 8'h0F, 3'd0);
    check("b2b_c1_gnt", 64'(in_gnt), 64'd0);
    check("b2b_c1_wdata", out_wdata, 64'h0000_0000_0000_000F);
    step(1'b1, 4'(AmoSwap), 1'b0, 32'd9, 64'h0000_0000_0000_0077, 8'h0F, 3'd0);
    check("b2b_c2_gnt", 64'(in_gnt), 64'd1);
    check("b2b_c2_wen", 64'(out_wen), 64'd0);
    @(negedge clk);
    rst    = 1'b1;
    in_req = 1'b0;
    #1;
    check("rst_doamo_req", 64'(out_req), 64'd0);
    check("rst_doamo_gnt", 64'(in_gnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 4'(AmoAdd), 1'b0, 32'd9, 64'h0000_0000_0000_0005, 8'h0F, 3'd0);
    check("post_rst_gnt", 64'(in_gnt), 64'd1);
    check("post_rst_wen", 64'(out_wen), 64'd0);
    idle();
    check("post_rst_rdata", in_rdata, 64'h0000_0000_0000_000F);
    check("post_rst_wdata", out_wdata, 64'h0000_0000_0000_0014);
    idle();
    check("post_rst_mem", mem[9], 64'h0000_0000_0000_0014);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
